// File: rtl/rx_adc_conditioner_pkg.sv
// Shared constants for the RX ADC conditioner: setting-bus addresses,
// datapath widths and RX_MUX field layout.
package rx_adc_conditioner_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int ADC_W  = 12;
    localparam int SMP_W  = 16;
    localparam int NCH    = 4;

    localparam int DEF_ADDR_DC_OFFSET_CL_EN = 39;
    localparam int DEF_ADDR_ADC_OFFSET_0    = 10;
    localparam int DEF_ADDR_ADC_OFFSET_1    = 11;
    localparam int DEF_ADDR_ADC_OFFSET_2    = 12;
    localparam int DEF_ADDR_ADC_OFFSET_3    = 13;
    localparam int DEF_ADDR_RX_MUX          = 38;

    localparam int MUX_W           = 20;
    localparam int MUX_NUMCHAN_LSB = 0;
    localparam int MUX_NUMCHAN_W   = 3;
    localparam int MUX_REAL_BIT    = 3;
    localparam int MUX_DDC_LSB     = 4;
    localparam int MUX_DDC_W       = 4;

    function automatic logic [MUX_DDC_W-1:0] ddc_sel(
        input logic [MUX_W-1:0] mux,
        input int               n
    );
        return mux[MUX_DDC_LSB + MUX_DDC_W*n +: MUX_DDC_W];
    endfunction

endpackage

// File: rtl/rx_dc_corrector.sv
// One channel of DC-offset removal: a 32-bit integrator whose rounded-
// toward-zero upper half is subtracted from the scaled sample.
module rx_dc_corrector
    import rx_adc_conditioner_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [SMP_W-1:0] preload,
    input  logic [ADC_W-1:0] adc,
    output logic [SMP_W-1:0] corr
);

    logic [31:0]      integ;
    logic [SMP_W-1:0] x;
    logic [SMP_W-1:0] s;

    assign x = {adc[ADC_W-1], adc, 3'b000};
    // Adding one to a negative value with a nonzero fraction rounds toward zero.
    assign s = integ[31:16] + {15'd0, integ[31] & (|integ[15:0])};
    assign corr = x - s;

    always_ff @(posedge clock) begin
        if (reset) begin
            integ <= '0;
        end else if (load) begin
            integ <= {preload, 16'h0000};
        end else if (en) begin
            integ <= integ + {{16{corr[SMP_W-1]}}, corr};
        end
    end

endmodule

// File: rtl/rx_level_meter.sv
// Leaky-integrator signal level and over-range meter for one ADC channel.
module rx_level_meter
    import rx_adc_conditioner_pkg::*;
(
    input  logic             clock,
    input  logic             clear,
    input  logic [ADC_W-1:0] adc,
    output logic [31:0]      rssi
);

    logic [25:0] level;
    logic [25:0] over;
    logic [10:0] mag;
    logic        flag;

    // Ones' complement magnitude keeps full scale negative at 0x7FF.
    assign mag  = adc[ADC_W-1] ? ~adc[10:0] : adc[10:0];
    assign flag = (adc == 12'h7FF) || (adc == 12'h800);
    assign rssi = {over[25:10], level[25:10]};

    always_ff @(posedge clock) begin
        if (clear) begin
            level <= '0;
            over  <= '0;
        end else begin
            level <= level + 26'(mag) - 26'(level[25:10]);
            over  <= over + (flag ? 26'd65535 : 26'd0) - 26'(over[25:10]);
        end
    end

endmodule

// File: rtl/rx_setting_reg.sv
// Generic setting-bus register: captures serial_data on a matching strobe
// and flags the write with a one-cycle changed pulse.
module rx_setting_reg
    import rx_adc_conditioner_pkg::*;
#(
    parameter int ADDR  = 0,
    parameter int WIDTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] serial_addr,
    input  logic [DATA_W-1:0] serial_data,
    input  logic              serial_strobe,
    output logic [WIDTH-1:0]  value,
    output logic              changed
);

    logic hit;
    logic unused_data;

    assign hit = serial_strobe && (serial_addr == ADDR_W'(ADDR));
    assign unused_data = ^serial_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            value   <= '0;
            changed <= 1'b0;
        end else begin
            changed <= hit;
            if (hit) value <= serial_data[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/rx_adc_conditioner.sv
// RX ADC front end: input registers, per-channel DC correction and level
// metering, and the DDC input crossbar driven by the RX_MUX register.
module rx_adc_conditioner
    import rx_adc_conditioner_pkg::*;
#(
    parameter int ADDR_DC_OFFSET_CL_EN = DEF_ADDR_DC_OFFSET_CL_EN,
    parameter int ADDR_ADC_OFFSET_0    = DEF_ADDR_ADC_OFFSET_0,
    parameter int ADDR_ADC_OFFSET_1    = DEF_ADDR_ADC_OFFSET_1,
    parameter int ADDR_ADC_OFFSET_2    = DEF_ADDR_ADC_OFFSET_2,
    parameter int ADDR_ADC_OFFSET_3    = DEF_ADDR_ADC_OFFSET_3,
    parameter int ADDR_RX_MUX          = DEF_ADDR_RX_MUX
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [ADDR_W-1:0] serial_addr,
    input  logic [DATA_W-1:0] serial_data,
    input  logic              serial_strobe,
    input  logic [ADC_W-1:0]  rx_a_a,
    input  logic [ADC_W-1:0]  rx_b_a,
    input  logic [ADC_W-1:0]  rx_a_b,
    input  logic [ADC_W-1:0]  rx_b_b,
    output logic [31:0]       rssi_0,
    output logic [31:0]       rssi_1,
    output logic [31:0]       rssi_2,
    output logic [31:0]       rssi_3,
    output logic [SMP_W-1:0]  ddc0_in_i,
    output logic [SMP_W-1:0]  ddc0_in_q,
    output logic [SMP_W-1:0]  ddc1_in_i,
    output logic [SMP_W-1:0]  ddc1_in_q,
    output logic [SMP_W-1:0]  ddc2_in_i,
    output logic [SMP_W-1:0]  ddc2_in_q,
    output logic [SMP_W-1:0]  ddc3_in_i,
    output logic [SMP_W-1:0]  ddc3_in_q,
    output logic [3:0]        rx_numchan
);

    logic [MUX_W-1:0] rx_mux;
    logic [NCH-1:0]   dco_en;
    logic             unused_mux_chg;
    logic             unused_dco_chg;
    logic [ADC_W-1:0] adc  [NCH];
    logic [SMP_W-1:0] corr [NCH];
    logic [31:0]      rssi [NCH];
    logic             meter_clear;

    assign meter_clear = reset || !enable;

    rx_setting_reg #(.ADDR(ADDR_RX_MUX), .WIDTH(MUX_W)) u_mux (
        .clock, .reset, .serial_addr, .serial_data, .serial_strobe,
        .value(rx_mux), .changed(unused_mux_chg)
    );

    rx_setting_reg #(.ADDR(ADDR_DC_OFFSET_CL_EN), .WIDTH(NCH)) u_dco (
        .clock, .reset, .serial_addr, .serial_data, .serial_strobe,
        .value(dco_en), .changed(unused_dco_chg)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            adc[0] <= '0;
            adc[1] <= '0;
            adc[2] <= '0;
            adc[3] <= '0;
        end else begin
            adc[0] <= rx_a_a;
            adc[1] <= rx_b_a;
            adc[2] <= rx_a_b;
            adc[3] <= rx_b_b;
        end
    end

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        localparam int OA = (n == 0) ? ADDR_ADC_OFFSET_0 :
                            (n == 1) ? ADDR_ADC_OFFSET_1 :
                            (n == 2) ? ADDR_ADC_OFFSET_2 :
                                       ADDR_ADC_OFFSET_3;
        logic [SMP_W-1:0] offset;
        logic             load;

        rx_setting_reg #(.ADDR(OA), .WIDTH(SMP_W)) u_off (
            .clock, .reset, .serial_addr, .serial_data, .serial_strobe,
            .value(offset), .changed(load)
        );

        rx_dc_corrector u_dc (
            .clock, .reset, .en(dco_en[n]), .load, .preload(offset),
            .adc(adc[n]), .corr(corr[n])
        );

        rx_level_meter u_lvl (
            .clock, .clear(meter_clear), .adc(adc[n]), .rssi(rssi[n])
        );
    end

    for (genvar d = 0; d < NCH; d++) begin : g_ddc
        logic [MUX_DDC_W-1:0] sel;
        logic [SMP_W-1:0]     ddc_i;
        logic [SMP_W-1:0]     ddc_q;

        assign sel = ddc_sel(rx_mux, d);

        always_ff @(posedge clock) begin
            if (reset) begin
                ddc_i <= '0;
                ddc_q <= '0;
            end else begin
                ddc_i <= corr[sel[1:0]];
                ddc_q <= rx_mux[MUX_REAL_BIT] ? '0 : corr[sel[3:2]];
            end
        end
    end

    assign ddc0_in_i = g_ddc[0].ddc_i;
    assign ddc0_in_q = g_ddc[0].ddc_q;
    assign ddc1_in_i = g_ddc[1].ddc_i;
    assign ddc1_in_q = g_ddc[1].ddc_q;
    assign ddc2_in_i = g_ddc[2].ddc_i;
    assign ddc2_in_q = g_ddc[2].ddc_q;
    assign ddc3_in_i = g_ddc[3].ddc_i;
    assign ddc3_in_q = g_ddc[3].ddc_q;

    assign rssi_0 = rssi[0];
    assign rssi_1 = rssi[1];
    assign rssi_2 = rssi[2];
    assign rssi_3 = rssi[3];

    assign rx_numchan = {rx_mux[MUX_NUMCHAN_LSB +: MUX_NUMCHAN_W], 1'b0};

endmodule

// File: tb/tb_rx_adc_conditioner.sv
// Scoreboard bench for rx_adc_conditioner: an arithmetic reference model
// predicts every cycle's outputs; a negedge monitor compares them.
module tb_rx_adc_conditioner;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        serial_strobe = 1'b0;
    logic [11:0] rx_a_a = '0, rx_b_a = '0, rx_a_b = '0, rx_b_b = '0;
    logic [31:0] rssi_0, rssi_1, rssi_2, rssi_3;
    logic [15:0] ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q;
    logic [15:0] ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q;
    logic [3:0]  rx_numchan;

    int checks = 0;
    int failures = 0;

    rx_adc_conditioner dut (
        .clock(clock), .reset(reset), .enable(enable),
        .serial_addr(serial_addr), .serial_data(serial_data),
        .serial_strobe(serial_strobe),
        .rx_a_a(rx_a_a), .rx_b_a(rx_b_a), .rx_a_b(rx_a_b), .rx_b_b(rx_b_b),
        .rssi_0(rssi_0), .rssi_1(rssi_1), .rssi_2(rssi_2), .rssi_3(rssi_3),
        .ddc0_in_i(ddc0_in_i), .ddc0_in_q(ddc0_in_q),
        .ddc1_in_i(ddc1_in_i), .ddc1_in_q(ddc1_in_q),
        .ddc2_in_i(ddc2_in_i), .ddc2_in_q(ddc2_in_q),
        .ddc3_in_i(ddc3_in_i), .ddc3_in_q(ddc3_in_q),
        .rx_numchan(rx_numchan)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [127:0] ddc;
        logic [127:0] rssi;
        logic [3:0]   nch;
    } exp_t;

    exp_t exp_q[$];
    bit   started = 0;

    // Reference state: plain integers, signed samples, real division.
    int          m_adc [4];
    int          m_int [4];
    int          m_off [4];
    bit          m_load [4];
    int          m_r [4];
    int          m_o [4];
    int unsigned m_mux = 0;
    int unsigned m_dco = 0;

    function automatic int corr_of(input int a, input int i);
        int x;
        int s;
        shortint c;
        x = a * 8;
        s = i / 65536;
        c = shortint'(x - s);
        return int'(c);
    endfunction

    function automatic int mag_of(input int a);
        return (a < 0) ? (-a - 1) : a;
    endfunction

    always @(posedge clock) begin : model
        int c [4];
        int p [4];
        int sel;
        bit wr;
        exp_t e;
        p[0] = int'($signed(rx_a_a));
        p[1] = int'($signed(rx_b_a));
        p[2] = int'($signed(rx_a_b));
        p[3] = int'($signed(rx_b_b));
        wr = serial_strobe && !reset;
        for (int n = 0; n < 4; n++) c[n] = corr_of(m_adc[n], m_int[n]);
        e = '0;
        for (int d = 0; d < 4; d++) begin
            sel = int'((m_mux >> (4 + 4*d)) & 15);
            if (!reset) begin
                e.ddc[127 - 32*d -: 16] = 16'(c[sel % 4]);
                if (((m_mux >> 3) & 1) == 0)
                    e.ddc[111 - 32*d -: 16] = 16'(c[sel / 4]);
            end
        end
        for (int n = 0; n < 4; n++) begin
            if (reset || !enable) begin
                m_r[n] = 0;
                m_o[n] = 0;
            end else begin
                m_r[n] = m_r[n] + mag_of(m_adc[n]) - m_r[n] / 1024;
                m_o[n] = m_o[n] - m_o[n] / 1024 +
                         ((m_adc[n] == 2047 || m_adc[n] == -2048) ? 65535 : 0);
            end
            e.rssi[127 - 32*n -: 32] = {16'(m_o[n] / 1024), 16'(m_r[n] / 1024)};
        end
        for (int n = 0; n < 4; n++) begin
            if (reset) m_int[n] = 0;
            else if (m_load[n]) m_int[n] = m_off[n] * 65536;
            else if (((m_dco >> n) & 1) != 0) m_int[n] = m_int[n] + c[n];
            m_load[n] = wr && (serial_addr == 7'(10 + n));
            if (reset) m_off[n] = 0;
            else if (m_load[n]) m_off[n] = int'(serial_data[15:0]);
            m_adc[n] = reset ? 0 : p[n];
        end
        if (reset) m_mux = 0;
        else if (wr && serial_addr == 7'd38) m_mux = serial_data & 32'hF_FFFF;
        if (reset) m_dco = 0;
        else if (wr && serial_addr == 7'd39) m_dco = serial_data & 32'hF;
        e.nch = {m_mux[2:0], 1'b0};
        exp_q.push_back(e);
        started = 1;
    end

    always @(negedge clock) begin : monitor
        exp_t e;
        logic [127:0] gd;
        logic [127:0] gr;
        if (started) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty t=%0t got=empty required=entry", $time);
            end else begin
                e = exp_q.pop_front();
                gd = {ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q,
                      ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q};
                gr = {rssi_0, rssi_1, rssi_2, rssi_3};
                checks += 3;
                if (gd !== e.ddc) begin
                    failures++;
                    $display("FAIL sb_ddc t=%0t got=%h required=%h", $time, gd, e.ddc);
                end
                if (gr !== e.rssi) begin
                    failures++;
                    $display("FAIL sb_rssi t=%0t got=%h required=%h", $time, gr, e.rssi);
                end
                if (rx_numchan !== e.nch) begin
                    failures++;
                    $display("FAIL sb_numchan t=%0t got=%h required=%h",
                             $time, rx_numchan, e.nch);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    task automatic chk_ge(input string name, input logic [31:0] got,
                          input logic [31:0] min);
        checks++;
        if (!(got >= min) || $isunknown(got)) begin
            failures++;
            $display("FAIL %s got=%h required>=%h", name, got, min);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        serial_addr = a;
        serial_data = d;
        serial_strobe = 1'b1;
        cyc(1);
        serial_strobe = 1'b0;
    endtask

    function automatic logic [31:0] any_out();
        return {31'd0, |{ddc0_in_i, ddc0_in_q, ddc1_in_i, ddc1_in_q,
                         ddc2_in_i, ddc2_in_q, ddc3_in_i, ddc3_in_q,
                         rssi_0, rssi_1, rssi_2, rssi_3, rx_numchan}};
    endfunction

    initial begin
        logic signed [15:0] prev;
        logic signed [15:0] first;
        bit mono;
        int unsigned a_pick [7];
        cyc(3);
        @(negedge clock);
        chk("reset_ddc0_i", 32'(ddc0_in_i), 32'h0);
        chk("reset_numchan", 32'(rx_numchan), 32'h0);
        chk("reset_all_zero", any_out(), 32'h0);

        reset = 1'b0;
        enable = 1'b1;
        rx_a_a = 12'h100;
        cyc(2);
        @(negedge clock);
        chk("basic_ddc0_i", 32'(ddc0_in_i), 32'h0800);
        chk("basic_ddc0_q", 32'(ddc0_in_q), 32'h0800);
        wr(7'd38, 32'h8);
        cyc(1);
        @(negedge clock);
        chk("realsig_q", 32'(ddc0_in_q), 32'h0);

        wr(7'd77, 32'hFFFF_FFFF);
        cyc(2);
        @(negedge clock);
        chk("nomatch_numchan", 32'(rx_numchan), 32'h0);
        chk("nomatch_ddc0_i", 32'(ddc0_in_i), 32'h0800);

        wr(7'd10, 32'h0000_0100);
        cyc(2);
        @(negedge clock);
        chk("offset_ddc0_i", 32'(ddc0_in_i), 32'h0700);
        cyc(10);
        @(negedge clock);
        chk("offset_hold", 32'(ddc0_in_i), 32'h0700);

        rx_b_a = 12'h200;
        rx_a_b = 12'h300;
        rx_b_b = 12'h0F0;
        wr(7'd38, 32'hB6);
        cyc(2);
        @(negedge clock);
        chk("route_ddc0_i", 32'(ddc0_in_i), 32'h0780);
        chk("route_ddc0_q", 32'(ddc0_in_q), 32'h1800);
        chk("route_numchan", 32'(rx_numchan), 32'hC);

        wr(7'd38, 32'h0);
        wr(7'd39, 32'h1);
        cyc(3);
        @(negedge clock);
        first = ddc0_in_i;
        prev = first;
        mono = 1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clock);
            if ($signed(ddc0_in_i) > prev) mono = 0;
            prev = ddc0_in_i;
        end
        chk("dc_monotonic", 32'(mono), 32'h1);
        chk("dc_decayed", 32'(prev < first), 32'h1);
        #1;
        wr(7'd39, 32'h0);

        rx_a_a = 12'h7FF;
        rx_b_a = 12'h800;
        rx_a_b = 12'h7FF;
        rx_b_b = 12'h7FF;
        cyc(15000);
        @(negedge clock);
        chk_ge("over_0", 32'(rssi_0[31:16]), 32'hFFFE);
        chk_ge("rssi_0", 32'(rssi_0[15:0]), 32'h07FE);
        chk_ge("rssi_1_neg", 32'(rssi_1[15:0]), 32'h07FE);
        chk_ge("over_1_neg", 32'(rssi_1[31:16]), 32'hFFFE);
        #1;
        enable = 1'b0;
        cyc(1);
        @(negedge clock);
        chk("disable_rssi_0", rssi_0, 32'h0);
        chk("disable_rssi_1", rssi_1, 32'h0);
        #1;
        enable = 1'b1;

        a_pick = '{10, 11, 12, 13, 38, 39, 0};
        for (int k = 0; k < 20000; k++) begin
            rx_a_a = 12'($urandom);
            rx_b_a = 12'($urandom);
            rx_a_b = 12'($urandom);
            rx_b_b = ($urandom_range(0, 3) == 0) ? 12'h800 : 12'($urandom);
            if ($urandom_range(0, 7) == 0) rx_a_a = 12'h7FF;
            serial_strobe = ($urandom_range(0, 15) == 0);
            a_pick[6] = $urandom_range(0, 127);
            serial_addr = 7'(a_pick[$urandom_range(0, 6)]);
            serial_data = $urandom;
            if ($urandom_range(0, 63) == 0) enable = ~enable;
            reset = ($urandom_range(0, 999) == 0);
            cyc(1);
        end

        reset = 1'b0;
        serial_strobe = 1'b0;
        enable = 1'b1;
        wr(7'd38, 32'h0001_B1E5);
        cyc(50);
        reset = 1'b1;
        cyc(1);
        @(negedge clock);
        chk("midrun_reset", any_out(), 32'h0);
        #1;
        reset = 1'b0;
        cyc(2);
        @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
